mul_sequencer: RTL and testbench
================================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter: MUL_LAT, default 2, number of cycles operands are held stable on mul_a/mul_b before mul_p is sampled (legal range 1..15).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 flush  in  1  abort in-flight operation and discard pending response.
REQ-005 req0_valid, req1_valid  in  1 each  requester operation valid.
REQ-006 req0_ready, req1_ready  out  1 each  requester accepted this cycle (valid & ready).
REQ-007 req0_op, req1_op  in  2 each  op code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
REQ-008 req0_a, req0_b, req1_a, req1_b  in  32 each  operands (a = multiplicand, b = multiplier).
REQ-009 mul_a, mul_b  out  32 each  operands to external shared 32x32 signed (two's-complement) multiplier.
REQ-010 mul_p  in  64  signed product from external multiplier, valid MUL_LAT cycles after operands change.
REQ-011 rsp_valid  out  1  result available.
REQ-012 rsp_ready  in  1  consumer takes result.
REQ-013 rsp_id  out  1  requester index of result.
REQ-014 rsp_data  out  32  result word.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, WAIT, FIX, RESP.
REQ-017 IDLE: grant one valid requester; on accept, register op, a, b, id; go to WAIT with counter = MUL_LAT-1.
REQ-018 req_ready asserted only in IDLE with flush low, only to the granted requester, combinationally from req*_valid.
REQ-019 Arbitration round-robin: if both valid, grant the one not served last; if one valid, grant it.
REQ-020 mul_a/mul_b driven from operand registers; held stable from cycle after accept until the next accept.
REQ-021 WAIT: decrement counter each cycle; at counter 0, register mul_p, go to FIX.
REQ-022 FIX (one cycle) computes result, H = mul_p[63:32]: MUL -> mul_p[31:0]; MULH -> H; MULHSU -> H + (b[31] ? a : 0); MULHU -> H + (a[31] ? b : 0) + (b[31] ? a : 0); all sums mod 2^32.
REQ-023 FIX -> RESP; rsp_valid, rsp_id, rsp_data registered, asserted first cycle of RESP.
REQ-024 Latency accept edge to rsp_valid high = MUL_LAT+2 cycles; throughput one op per MUL_LAT+3 cycles minimum.
REQ-025 RESP: hold rsp_valid/rsp_id/rsp_data stable until rsp_valid & rsp_ready; then IDLE, rsp_valid low next cycle.
REQ-026 No new request accepted in the cycle rsp handshake completes (req_ready low outside IDLE).
REQ-027 flush high in WAIT, FIX or RESP: next state IDLE, rsp_valid low next cycle, no response ever issued for that op; round-robin pointer unchanged.
REQ-028 flush high in IDLE: no accept that cycle.
REQ-029 flush has priority over rsp_ready handshake in same cycle.

Reset
REQ-030 rst asserted: immediately state IDLE, counter 0, rsp_valid 0, rsp_id 0, rsp_data 0, mul_a/mul_b 0, busy 0, req_ready 0 while rst high.
REQ-031 Round-robin pointer resets to "last served = 1" so req0 wins first contention.
REQ-032 Reset mid-operation discards operation; no response after release.

Structure
REQ-033 Shared package mul_pkg holds op code constants (MUL, MULH, MULHSU, MULHU) and FSM state encoding.
REQ-034 One sub-module rr_arb2 (2-requester round-robin arbiter, grant + pointer update on accept); multiplier stays external.

Verification
REQ-035 MUL_LAT=2, req0 MUL a=7 b=6 -> rsp_valid 4 cycles after accept, rsp_data=42, rsp_id=0.
REQ-036 a=b=0xFFFFFFFF: MUL -> 0x00000001; MULH -> 0x00000000; MULHU -> 0xFFFFFFFE.
REQ-037 MULHSU a=0xFFFFFFFF b=0x80000000 -> 0xFFFFFFFF; MULHU a=0x80000000 b=2 -> 0x00000001.
REQ-038 Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_ready held low 3 cycles -> rsp_data/rsp_id stable throughout.
REQ-039 flush in second WAIT cycle -> no rsp_valid, busy low next cycle, following req1 MUL 3x5 returns 15 with rsp_id=1.
REQ-040 rst pulsed during FIX -> all outputs 0 asynchronously; first post-reset contention granted to req0.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// Op codes, FSM encoding and the high-word fix-up shared by the multiply sequencer.
// The external multiplier is always signed; the unsigned variants are derived here.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIX  = 2'd2,
    ST_RESP = 2'd3
  } seq_state_e;

  localparam int unsigned CNT_W = 4;

  // A negative operand read as unsigned gains 2^32, adding the other operand to the high word.
  function automatic logic [31:0] fix_result(mul_op_e op, logic [31:0] a, logic [31:0] b,
                                             logic [63:0] p);
    logic [31:0] h;
    logic [31:0] corr_a;
    logic [31:0] corr_b;
    logic [31:0] res;
    h      = p[63:32];
    corr_a = b[31] ? a : 32'd0;
    corr_b = a[31] ? b : 32'd0;
    case (op)
      MUL:     res = p[31:0];
      MULH:    res = h;
      MULHSU:  res = h + corr_a;
      default: res = h + corr_a + corr_b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Request, response and multiplier-port bundle of the multiply sequencer.
// slave is the sequencer side, master is the surrounding system side.
interface mul_sequencer_if;

  logic        flush;

  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;

  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_p;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;

  logic        busy;

  modport slave (
    input  flush,
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output mul_a, mul_b,
    input  mul_p,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready,
    output busy
  );

  modport master (
    output flush,
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  mul_a, mul_b,
    output mul_p,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready,
    input  busy
  );

endinterface

// File: rtl/mul_sequencer_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer only moves on an accepted grant.
// Out of reset requester 0 wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_id = 1'b0;
    if (req == 2'b11) begin
      gnt_id = ~last_q;
    end else if (req[1]) begin
      gnt_id = 1'b1;
    end
    gnt    = {(req != 2'b00) &  gnt_id,
              (req != 2'b00) & ~gnt_id};
    last_d = last_q;
    if (accept) begin
      last_d = gnt_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multiply sequencer: shares one external 32x32 signed multiplier between two
// requesters and derives MUL/MULH/MULHSU/MULHU results from its signed product.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  mul_sequencer_if.slave bus
);

  // state | meaning
  // IDLE  | nothing in flight, may accept one request
  // WAIT  | operands held on mul_a/mul_b, counting down MUL_LAT cycles
  // FIX   | product captured, forming the op-specific result word
  // RESP  | result presented until rsp_ready

  seq_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mul_op_e     op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        id_q, id_d;
  logic [63:0] p_q, p_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic [1:0]  req_vec;
  logic [1:0]  gnt;
  logic        gnt_id;
  logic        can_accept;
  logic        accept;

  assign req_vec    = {bus.req1_valid, bus.req0_valid};
  // rst gates ready too, since state reads IDLE throughout reset
  assign can_accept = (state_q == ST_IDLE) & ~bus.flush & ~rst;
  assign accept     = can_accept & (req_vec != 2'b00);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .accept (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign bus.req0_ready = can_accept & gnt[0];
  assign bus.req1_ready = can_accept & gnt[1];
  assign bus.mul_a      = a_q;
  assign bus.mul_b      = b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    p_d         = p_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = mul_op_e'(gnt_id ? bus.req1_op : bus.req0_op);
          a_d     = gnt_id ? bus.req1_a : bus.req0_a;
          b_d     = gnt_id ? bus.req1_b : bus.req0_b;
          id_d    = gnt_id;
          cnt_d   = CNT_W'(MUL_LAT - 32'd1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          p_d     = bus.mul_p;
          state_d = ST_FIX;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_FIX: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = fix_result(op_q, a_q, b_q, p_q);
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        // flush wins over a simultaneous handshake; both just drop the response
        if (bus.flush || bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= MUL;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      p_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      p_q         <= p_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: accepts push expected results, a negedge
// monitor compares every cycle against a cycle-level behavioural model.
module tb_mul_sequencer;
  import mul_pkg::*;

  localparam int unsigned MUL_LAT = 2;
  localparam int RSP_LAT = MUL_LAT + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_sequencer_if bus ();

  mul_sequencer #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External signed multiplier: product settles MUL_LAT cycles after operands change
  logic [63:0] prod;
  logic [63:0] stage [0:15];
  assign prod = {{32{bus.mul_a[31]}}, bus.mul_a} * {{32{bus.mul_b[31]}}, bus.mul_b};
  always @(posedge clk) begin
    stage[0] <= prod;
    for (int i = 1; i < 16; i++) stage[i] <= stage[i-1];
  end
  generate
    if (MUL_LAT == 1) begin : g_comb
      assign bus.mul_p = prod;
    end else begin : g_pipe
      assign bus.mul_p = stage[MUL_LAT-2];
    end
  endgenerate

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic        last_served = 1'b1;
  logic [31:0] last_rsp_data;
  logic        last_rsp_id;
  bit          rnd_on;

  function automatic logic [31:0] ref_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0, 2'd1: p = sa * sb;
      2'd2:       p = sa * ub;
      default:    p = ua * ub;
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_flags"}, {59'd0, bus.rsp_valid, bus.rsp_id, bus.busy, bus.req0_ready, bus.req1_ready}, 64'd0);
    chk({tag, "_rsp_data"}, {32'd0, bus.rsp_data}, 64'd0);
    chk({tag, "_mul_ab"}, {bus.mul_a, bus.mul_b}, 64'd0);
  endtask

  // Monitor and reference model
  always @(negedge clk) begin
    exp_t       e;
    logic       pending;
    logic       exp_rv;
    logic       idle;
    logic       gid;
    logic [1:0] vld;
    cyc++;
    if (rst) begin
      chk_outputs_zero("reset");
    end else begin
      pending = (exp_q.size() != 0);
      exp_rv  = 1'b0;
      chk("busy", bus.busy, pending);
      if (pending) begin
        e      = exp_q[0];
        exp_rv = ((cyc - e.acc) >= RSP_LAT);
        chk("mul_ab", {bus.mul_a, bus.mul_b}, {e.a, e.b});
        chk("rsp_valid", bus.rsp_valid, exp_rv);
        if (exp_rv) begin
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_data", bus.rsp_data, ref_result(e.op, e.a, e.b));
        end
        if (bus.flush) begin
          void'(exp_q.pop_front());
        end else if (exp_rv && bus.rsp_ready) begin
          last_rsp_data = bus.rsp_data;
          last_rsp_id   = bus.rsp_id;
          void'(exp_q.pop_front());
        end
      end else begin
        chk("rsp_valid_idle", bus.rsp_valid, 1'b0);
      end
      vld  = {bus.req1_valid, bus.req0_valid};
      idle = !pending && !bus.flush && (vld != 2'b00);
      gid  = (vld == 2'b11) ? !last_served : vld[1];
      chk("req0_ready", bus.req0_ready, idle && !gid);
      chk("req1_ready", bus.req1_ready, idle && gid);
      if (idle) begin
        e.id  = gid;
        e.op  = gid ? bus.req1_op : bus.req0_op;
        e.a   = gid ? bus.req1_a : bus.req0_a;
        e.b   = gid ? bus.req1_b : bus.req0_b;
        e.acc = cyc;
        exp_q.push_back(e);
        last_served = gid;
      end
    end
  end

  task automatic drive(input bit id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    bit done;
    n = 0;
    done = 0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    while (!done) begin
      @(negedge clk);
      if (!rst && (id ? bus.req1_ready : bus.req0_ready)) begin
        done = 1;
      end else begin
        n++;
        if (n > 300) begin
          vectors++;
          miscompares++;
          $display("FAIL accept_timeout req%0d: got no ready, want ready within 300 cycles", id);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d responses outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [1:0]  d_op  [5] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3};
  logic [31:0] d_a   [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
  logic [31:0] d_b   [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2};
  logic [31:0] d_res [5] = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001};

  initial begin
    rst = 1'b1;
    rnd_on = 0;
    bus.flush = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = 2'd0; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
    bus.req1_valid = 1'b1; bus.req1_op = 2'd0; bus.req1_a = 32'd1; bus.req1_b = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 7 x 6 from req0
    last_rsp_data = 32'hDEAD_BEEF;
    drive(0, MUL, 32'd7, 32'd6);
    wait_drain();
    chk("mul_7x6", {31'd0, last_rsp_id, last_rsp_data}, {31'd0, 1'b0, 32'd42});

    // corner operands
    for (int i = 0; i < 5; i++) begin
      last_rsp_data = 32'hDEAD_BEEF;
      drive(0, d_op[i], d_a[i], d_b[i]);
      wait_drain();
      chk("corner_result", {32'd0, last_rsp_data}, {32'd0, d_res[i]});
    end

    // continuous contention, grants alternate
    fork
      begin
        for (int i = 0; i < 4; i++) drive(0, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd());
      end
      begin
        for (int j = 0; j < 4; j++) drive(1, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd());
      end
    join
    wait_drain();

    // response held while rsp_ready low
    bus.rsp_ready = 1'b0;
    drive(1, MULHU, rand_opnd(), rand_opnd());
    begin
      int n;
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_drain();

    // flush in second WAIT cycle
    drive(0, MUL, 32'd9, 32'd9);
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_rv", {62'd0, bus.busy, bus.rsp_valid}, 64'd0);
    repeat (6) @(posedge clk);
    #1;
    last_rsp_data = 32'hDEAD_BEEF;
    drive(1, MUL, 32'd3, 32'd5);
    wait_drain();
    chk("after_flush_3x5", {31'd0, last_rsp_id, last_rsp_data}, {31'd0, 1'b1, 32'd15});

    // asynchronous reset during FIX
    drive(0, MULH, rand_opnd(), rand_opnd());
    @(posedge clk);
    @(posedge clk);
    #2;
    bus.req0_valid = 1'b1;
    rst = 1'b1;
    exp_q.delete();
    last_served = 1'b1;
    #1;
    chk_outputs_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    fork
      drive(0, MUL, rand_opnd(), rand_opnd());
      drive(1, MUL, rand_opnd(), rand_opnd());
    join
    wait_drain();

    // randomized traffic with random rsp_ready and flush pulses
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          bus.rsp_ready = 1'($urandom_range(0, 1));
          bus.flush     = ($urandom_range(0, 15) == 0);
        end
      end
    join_none
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          drive(0, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd());
        end
      end
      begin
        for (int j = 0; j < 20; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          drive(1, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd());
        end
      end
    join
    rnd_on = 0;
    repeat (2) @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: got no end of test, want finish before 500000 time units");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
